// File: rtl/smpc_intback_sched_pkg.sv
// Shared types and byte formatting for the INTBACK peripheral scan scheduler.
// Pure definitions: no state, no latency, no flow control.
package smpc_intback_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PORT,
    ST_REQ,
    ST_EMIT,
    ST_HOLD,
    ST_FLUSH
  } intback_st_t;

  localparam logic [7:0] PAD_HDR_DIG = 8'hF1;
  localparam logic [7:0] PAD_ID_DIG  = 8'h02;
  localparam logic [7:0] PAD_NONE    = 8'hF0;
  localparam logic [7:0] TAP_HDR     = 8'h16;
  localparam logic [2:0] TAP_LAST_SLOT = 3'd5;

  // Byte idx of a slot entry; an absent slot is a single PAD_NONE byte.
  function automatic logic [7:0] pad_byte(input logic [1:0] idx, input logic present,
                                          input logic [15:0] data);
    logic [7:0] b;
    b = PAD_NONE;
    if (present) begin
      case (idx)
        2'd0:    b = PAD_HDR_DIG;
        2'd1:    b = PAD_ID_DIG;
        2'd2:    b = data[15:8];
        default: b = data[7:0];
      endcase
    end
    return b;
  endfunction

  function automatic logic [1:0] entry_last(input logic present);
    return present ? 2'd3 : 2'd0;
  endfunction

endpackage

// File: rtl/smpc_intback_sched_if.sv
// Command-core, pad-bus and OREG signals of the INTBACK scheduler.
// master drives commands and pad responses; slave is the scheduler itself.
interface smpc_intback_sched_if;
  logic        ce;
  logic        start;
  logic        cont;
  logic        brk;
  logic [1:0]  tap;
  logic        pad_req;
  logic        pad_port;
  logic [2:0]  pad_slot;
  logic        pad_ack;
  logic        pad_present;
  logic [15:0] pad_data;
  logic        oreg_we;
  logic [4:0]  oreg_addr;
  logic [7:0]  oreg_data;
  logic        busy;
  logic        more;
  logic        irq;

  modport master (
    output ce, start, cont, brk, tap, pad_ack, pad_present, pad_data,
    input  pad_req, pad_port, pad_slot, oreg_we, oreg_addr, oreg_data, busy, more, irq
  );

  modport slave (
    input  ce, start, cont, brk, tap, pad_ack, pad_present, pad_data,
    output pad_req, pad_port, pad_slot, oreg_we, oreg_addr, oreg_data, busy, more, irq
  );
endinterface

// File: rtl/smpc_intback_sched.sv
// INTBACK scan: settle, poll each pad slot, stream formatted bytes into OREG chunk by chunk.
// START to first PAD_REQ is SCAN_WAIT+1 CE cycles; a full chunk stalls in HOLD until CONT or BREAK.
module smpc_intback_sched
  import smpc_intback_sched_pkg::*;
#(
  parameter int SCAN_WAIT   = 4000,
  parameter int CHUNK_BYTES = 32,
  parameter int PAD_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  smpc_intback_sched_if.slave  bus
);

  intback_st_t state_q, state_d;
  intback_st_t resume_q, resume_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [4:0]  addr_q, addr_d;
  logic        port_q, port_d;
  logic [2:0]  slot_q, slot_d;
  logic [1:0]  idx_q, idx_d;
  logic        pres_q, pres_d;
  logic [15:0] data_q, data_d;
  logic        irq_pend_q, irq_pend_d;
  logic        pad_req_q, pad_req_d;
  logic        oreg_we_q, oreg_we_d;
  logic [4:0]  oreg_addr_q, oreg_addr_d;
  logic [7:0]  oreg_data_q, oreg_data_d;
  logic        busy_q, busy_d;
  logic        more_q, more_d;
  logic        irq_q, irq_d;

  logic        wr_en;
  logic [7:0]  wr_byte;
  logic        last_scan;

  always_comb begin
    state_d     = state_q;
    resume_d    = resume_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    port_d      = port_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    pres_d      = pres_q;
    data_d      = data_q;
    irq_pend_d  = irq_pend_q;
    pad_req_d   = pad_req_q;
    oreg_we_d   = oreg_we_q;
    oreg_addr_d = oreg_addr_q;
    oreg_data_d = oreg_data_q;
    busy_d      = busy_q;
    more_d      = more_q;
    irq_d       = irq_q;
    wr_en       = 1'b0;
    wr_byte     = 8'h00;
    last_scan   = 1'b0;

    if (bus.ce) begin
      irq_d     = 1'b0;
      oreg_we_d = 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_WAIT;
            cnt_d   = 16'(SCAN_WAIT - 1);
            addr_d  = 5'd0;
            port_d  = 1'b0;
            slot_d  = 3'd0;
            more_d  = 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 16'd0) state_d = ST_PORT;
          else                cnt_d   = cnt_q - 16'd1;
        end
        ST_PORT: begin
          slot_d  = 3'd0;
          state_d = ST_REQ;
          if (bus.tap[port_q]) begin
            wr_en   = 1'b1;
            wr_byte = TAP_HDR;
          end
        end
        ST_REQ: begin
          if (bus.pad_ack) begin
            pres_d  = bus.pad_present;
            data_d  = bus.pad_data;
            idx_d   = 2'd0;
            state_d = ST_EMIT;
          end else if (tmo_q == 16'd0) begin
            pres_d  = 1'b0;
            idx_d   = 2'd0;
            state_d = ST_EMIT;
          end else begin
            tmo_d = tmo_q - 16'd1;
          end
        end
        ST_EMIT: begin
          wr_en   = 1'b1;
          wr_byte = pad_byte(idx_q, pres_q, data_q);
          if (idx_q != entry_last(pres_q)) begin
            idx_d = idx_q + 2'd1;
          end else if (bus.tap[port_q] && slot_q < TAP_LAST_SLOT) begin
            slot_d  = slot_q + 3'd1;
            state_d = ST_REQ;
          end else if (!port_q) begin
            port_d  = 1'b1;
            slot_d  = 3'd0;
            state_d = ST_PORT;
          end else begin
            state_d   = ST_FLUSH;
            last_scan = 1'b1;
          end
        end
        ST_HOLD: begin
          // The chunk IRQ fires one CE after the last write; CONT only counts once it has.
          if (irq_pend_q) begin
            irq_pend_d = 1'b0;
            irq_d      = 1'b1;
            more_d     = 1'b1;
          end else if (bus.cont) begin
            more_d  = 1'b0;
            addr_d  = 5'd0;
            state_d = resume_q;
          end
        end
        ST_FLUSH: begin
          irq_d   = 1'b1;
          more_d  = 1'b0;
          port_d  = 1'b0;
          slot_d  = 3'd0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (wr_en) begin
        oreg_we_d   = 1'b1;
        oreg_addr_d = addr_q;
        oreg_data_d = wr_byte;
        if (addr_q == 5'(CHUNK_BYTES - 1)) begin
          addr_d = 5'd0;
          // Park the natural successor so CONT can pick up mid-entry if needed.
          if (!last_scan) begin
            resume_d   = state_d;
            state_d    = ST_HOLD;
            irq_pend_d = 1'b1;
          end
        end else begin
          addr_d = addr_q + 5'd1;
        end
      end

      if (state_q != ST_IDLE && bus.brk) begin
        state_d    = ST_IDLE;
        more_d     = 1'b0;
        irq_d      = 1'b0;
        oreg_we_d  = 1'b0;
        irq_pend_d = 1'b0;
        port_d     = 1'b0;
        slot_d     = 3'd0;
      end

      if (state_d == ST_REQ && state_q != ST_REQ) tmo_d = 16'(PAD_TIMEOUT - 1);
      pad_req_d = (state_d == ST_REQ);
      busy_d    = (state_d != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      resume_q    <= ST_IDLE;
      cnt_q       <= 16'd0;
      tmo_q       <= 16'd0;
      addr_q      <= 5'd0;
      port_q      <= 1'b0;
      slot_q      <= 3'd0;
      idx_q       <= 2'd0;
      pres_q      <= 1'b0;
      data_q      <= 16'd0;
      irq_pend_q  <= 1'b0;
      pad_req_q   <= 1'b0;
      oreg_we_q   <= 1'b0;
      oreg_addr_q <= 5'd0;
      oreg_data_q <= 8'd0;
      busy_q      <= 1'b0;
      more_q      <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      port_q      <= port_d;
      slot_q      <= slot_d;
      idx_q       <= idx_d;
      pres_q      <= pres_d;
      data_q      <= data_d;
      irq_pend_q  <= irq_pend_d;
      pad_req_q   <= pad_req_d;
      oreg_we_q   <= oreg_we_d;
      oreg_addr_q <= oreg_addr_d;
      oreg_data_q <= oreg_data_d;
      busy_q      <= busy_d;
      more_q      <= more_d;
      irq_q       <= irq_d;
    end
  end

  assign bus.pad_req   = pad_req_q;
  assign bus.pad_port  = port_q;
  assign bus.pad_slot  = slot_q;
  assign bus.oreg_we   = oreg_we_q;
  assign bus.oreg_addr = oreg_addr_q;
  assign bus.oreg_data = oreg_data_q;
  assign bus.busy      = busy_q;
  assign bus.more      = more_q;
  assign bus.irq       = irq_q;

endmodule

// File: tb/tb_smpc_intback_sched.sv
// Randomised INTBACK scans against a byte-list reference model; a monitor pops expected
// OREG writes and IRQs from a queue as the scheduler produces them.
module tb_smpc_intback_sched;

  localparam int SW  = 100;
  localparam int CH  = 32;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smpc_intback_sched_if bus();

  smpc_intback_sched #(.SCAN_WAIT(SW), .CHUNK_BYTES(CH), .PAD_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       is_irq;
    bit [4:0] addr;
    bit [7:0] data;
    bit       more;
  } ev_t;

  ev_t         exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit [11:0]   pres_tab;
  logic [15:0] data_tab [12];
  bit          ack_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: flatten the scan into its byte list, then cut it into chunks.
  function automatic void push_scan(input bit [1:0] tp, input bit stop_at_hold);
    bit [7:0] b[$];
    ev_t      e;
    int       len;
    for (int p = 0; p < 2; p++) begin
      if (tp[p]) b.push_back(8'h16);
      for (int s = 0; s < (tp[p] ? 6 : 1); s++) begin
        if (ack_en && pres_tab[p*6+s]) begin
          b.push_back(8'hF1);
          b.push_back(8'h02);
          b.push_back(data_tab[p*6+s][15:8]);
          b.push_back(data_tab[p*6+s][7:0]);
        end else begin
          b.push_back(8'hF0);
        end
      end
    end
    len = b.size();
    for (int i = 0; i < len; i++) begin
      e.is_irq = 1'b0; e.addr = 5'(i % CH); e.data = b[i]; e.more = 1'b0;
      exp_q.push_back(e);
      if (i % CH == CH - 1 && i < len - 1) begin
        e.is_irq = 1'b1; e.addr = 5'd0; e.data = 8'd0; e.more = 1'b1;
        exp_q.push_back(e);
        if (stop_at_hold) return;
      end
    end
    e.is_irq = 1'b1; e.addr = 5'd0; e.data = 8'd0; e.more = 1'b0;
    exp_q.push_back(e);
  endfunction

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ce && (bus.oreg_we || bus.irq)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_event: we=%0b irq=%0b addr=%0d data=0x%0h, want no event",
                   bus.oreg_we, bus.irq, bus.oreg_addr, bus.oreg_data);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_irq", {31'd0, bus.irq}, {31'd0, e.is_irq});
          if (e.is_irq) begin
            chk("irq_more", {31'd0, bus.more}, {31'd0, e.more});
          end else begin
            chk("wr_addr", {27'd0, bus.oreg_addr}, {27'd0, e.addr});
            chk("wr_data", {24'd0, bus.oreg_data}, {24'd0, e.data});
          end
        end
      end
    end
  end

  initial begin : pad_model
    int dly;
    int idx;
    dly = -1;
    bus.pad_ack = 1'b0;
    bus.pad_present = 1'b0;
    bus.pad_data = 16'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.pad_ack = 1'b0;
        dly = -1;
      end else if (bus.pad_ack) begin
        if (!bus.pad_req) bus.pad_ack = 1'b0;
      end else if (bus.pad_req && ack_en) begin
        if (dly < 0) dly = int'($urandom_range(0, 4));
        if (dly == 0) begin
          idx = int'(bus.pad_port) * 6 + int'(bus.pad_slot);
          bus.pad_ack     = 1'b1;
          bus.pad_present = pres_tab[idx];
          bus.pad_data    = data_tab[idx];
          dly = -1;
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_pad_req"},   {31'd0, bus.pad_req},   32'd0);
    chk({tag, "_pad_port"},  {31'd0, bus.pad_port},  32'd0);
    chk({tag, "_pad_slot"},  {29'd0, bus.pad_slot},  32'd0);
    chk({tag, "_oreg_we"},   {31'd0, bus.oreg_we},   32'd0);
    chk({tag, "_oreg_addr"}, {27'd0, bus.oreg_addr}, 32'd0);
    chk({tag, "_oreg_data"}, {24'd0, bus.oreg_data}, 32'd0);
    chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
    chk({tag, "_more"},      {31'd0, bus.more},      32'd0);
    chk({tag, "_irq"},       {31'd0, bus.irq},       32'd0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  // lat_mode: 0 none, 1 measure START->PAD_REQ, 2 measure with a 10-cycle CE gap in WAIT.
  task automatic run_scan(input bit [1:0] tp, input bit brk_mode, input int lat_mode,
                          input bit dbl_start);
    int n;
    bit done;
    bus.tap = tp;
    push_scan(tp, brk_mode);
    pulse_start();
    if (lat_mode != 0) begin
      n = 0;
      while (n < SW + 50) begin
        @(posedge clk); #1;
        n++;
        if (lat_mode == 2 && n == 5)  bus.ce = 1'b0;
        if (lat_mode == 2 && n == 15) bus.ce = 1'b1;
        if (bus.pad_req) break;
      end
      chk(lat_mode == 2 ? "latency_ce_gap" : "latency", n, SW + 1 + (lat_mode == 2 ? 10 : 0));
    end
    if (dbl_start) begin
      repeat (10) @(posedge clk);
      pulse_start();
    end
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (!bus.busy) begin
        done = 1'b1;
      end else if (bus.more) begin
        @(posedge clk); #1;
        if (brk_mode) bus.brk = 1'b1; else bus.cont = 1'b1;
        @(posedge clk); #1;
        bus.brk = 1'b0;
        bus.cont = 1'b0;
      end
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL scan_timeout: busy=1 after 20000 cycles, want 0");
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("end_busy", {31'd0, bus.busy}, 32'd0);
    chk("end_more", {31'd0, bus.more}, 32'd0);
    chk("end_pad_req", {31'd0, bus.pad_req}, 32'd0);
    exp_q.delete();
  endtask

  task automatic rand_data();
    for (int i = 0; i < 12; i++) data_tab[i] = 16'($urandom);
  endtask

  initial begin : main
    bit found;
    bus.ce = 1'b1;
    bus.start = 1'b0;
    bus.cont = 1'b0;
    bus.brk = 1'b0;
    bus.tap = 2'b00;
    rand_data();
    pres_tab = '0;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Both direct, both present
    pres_tab = '0;
    pres_tab[0] = 1'b1;
    pres_tab[6] = 1'b1;
    data_tab[0] = 16'hFFF7;
    data_tab[6] = 16'h7FFF;
    run_scan(2'b00, 1'b0, 1, 1'b0);

    // Port 0 multitap with slots 0 and 3 present, port 1 absent
    rand_data();
    pres_tab = '0;
    pres_tab[0] = 1'b1;
    pres_tab[3] = 1'b1;
    run_scan(2'b01, 1'b0, 0, 1'b0);

    // Two full multitaps: 50 bytes straddle the chunk boundary
    rand_data();
    pres_tab = '1;
    run_scan(2'b11, 1'b0, 0, 1'b0);

    // BREAK in HOLD, then a fresh scan from port 0
    rand_data();
    run_scan(2'b11, 1'b1, 0, 1'b0);
    rand_data();
    run_scan(2'b11, 1'b0, 0, 1'b0);

    // No pad ever answers: every slot times out
    ack_en = 1'b0;
    run_scan(2'b11, 1'b0, 0, 1'b0);
    ack_en = 1'b1;

    // Reset during EMIT
    pres_tab = '1;
    bus.tap = 2'b00;
    push_scan(2'b00, 1'b0);
    pulse_start();
    found = 1'b0;
    for (int c = 0; c < SW + 200 && !found; c++) begin
      @(negedge clk);
      if (bus.oreg_we) found = 1'b1;
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL reset_test_no_write: oreg_we=0 within budget, want 1");
    end
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midscan_reset");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);

    // Redundant START while busy, then CE gap during WAIT
    rand_data();
    run_scan(2'b00, 1'b0, 0, 1'b1);
    rand_data();
    run_scan(2'b00, 1'b0, 2, 1'b0);

    for (int it = 0; it < 8; it++) begin
      rand_data();
      pres_tab = 12'($urandom);
      run_scan(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
